kmap_sweep_checker: RTL and testbench

Self-checking stimulus stage that sits directly upstream of a 4-input K-map block. It drives the block's a/b/c/d inputs with all 16 input combinations, from 0 to 15. For each combination it waits a settle window, then samples the block's out_sop and out_pos results. Both results are compared against a golden truth table, and mismatches are counted. It replaces the free-running pattern loop with a clocked, restartable sweep engine that can be used on hardware and in regression.

---
 rtl/kmap_sweep_checker_if.sv | 49 ++++
 rtl/kmap_sweep_checker.sv | 123 ++++++++++++
 tb/tb_kmap_sweep_checker.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/kmap_sweep_checker_if.sv
// Signal bundle between the sweep checker and the K-map block it exercises.
// The master side is the checker; the slave side is the K-map block plus whoever reads status.
interface kmap_sweep_checker_if;
   logic       start;
   logic       a;
   logic       b;
   logic       c;
   logic       d;
   logic       out_sop;
   logic       out_pos;
   logic       busy;
   logic       done;
   logic       pass;
   logic [4:0] err_cnt;
   logic [3:0] first_err_idx;
   logic       disagree;

   modport master (
      input  start,
      input  out_sop,
      input  out_pos,
      output a,
      output b,
      output c,
      output d,
      output busy,
      output done,
      output pass,
      output err_cnt,
      output first_err_idx,
      output disagree
   );

   modport slave (
      output start,
      output out_sop,
      output out_pos,
      input  a,
      input  b,
      input  c,
      input  d,
      input  busy,
      input  done,
      input  pass,
      input  err_cnt,
      input  first_err_idx,
      input  disagree
   );
endinterface

// File: rtl/kmap_sweep_checker.sv
// Restartable sweep engine: walks {a,b,c,d} through 0..15, holds each vector for
// SETTLE_CYCLES, samples the K-map outputs and scores them against TRUTH_TABLE.
module kmap_sweep_checker #(
   parameter logic [15:0] TRUTH_TABLE   = 16'hD2B4,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   kmap_sweep_checker_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [3:0] LAST_IDX    = 4'd15;

   state_t     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [4:0] err_cnt_q, err_cnt_d;
   logic [3:0] first_err_q, first_err_d;
   logic       disagree_q, disagree_d;

   logic       start_ok;
   logic       exp_bit;
   logic       vec_fail;
   logic       vec_split;

   // A start is only honoured when no sweep is running.
   assign start_ok  = bus.start && ((state_q == IDLE) || (state_q == DONE));
   assign exp_bit   = TRUTH_TABLE[idx_q];
   // Case inequality so an X/Z from the block under test is scored as a failure.
   assign vec_fail  = (bus.out_sop !== exp_bit) || (bus.out_pos !== exp_bit);
   assign vec_split = (bus.out_sop !== bus.out_pos);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start_ok) state_d = SETTLE;
         end
         SETTLE: begin
            if (cnt_q == 4'd0) state_d = SAMPLE;
         end
         SAMPLE: begin
            state_d = (idx_q == LAST_IDX) ? DONE : SETTLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      disagree_d  = disagree_q;
      if (start_ok) begin
         idx_d       = 4'd0;
         cnt_d       = SETTLE_LOAD;
         err_cnt_d   = 5'd0;
         first_err_d = 4'd0;
         disagree_d  = 1'b0;
      end else if (state_q == SETTLE) begin
         if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end else if (state_q == SAMPLE) begin
         if (vec_fail) begin
            err_cnt_d = err_cnt_q + 5'd1;
            if (err_cnt_q == 5'd0) first_err_d = idx_q;
         end
         if (vec_split) disagree_d = 1'b1;
         // The final vector leaves idx parked at 15 for inspection.
         if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 4'd1;
            cnt_d = SETTLE_LOAD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= 4'd0;
         cnt_q       <= 4'd0;
         err_cnt_q   <= 5'd0;
         first_err_q <= 4'd0;
         disagree_q  <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         disagree_q  <= disagree_d;
      end
   end

   // Status is decoded from the state register, so reset clears it with no extra flops.
   always_comb begin
      bus.a             = idx_q[3];
      bus.b             = idx_q[2];
      bus.c             = idx_q[1];
      bus.d             = idx_q[0];
      bus.busy          = (state_q == SETTLE) || (state_q == SAMPLE);
      bus.done          = (state_q == DONE);
      bus.pass          = (state_q == DONE) && (err_cnt_q == 5'd0);
      bus.err_cnt       = err_cnt_q;
      bus.first_err_idx = first_err_q;
      bus.disagree      = disagree_q;
   end

endmodule

// File: tb/tb_kmap_sweep_checker.sv
// Directed bench for kmap_sweep_checker: a behavioural K-map with selectable faults
// drives the default build, and a delayed K-map drives a SETTLE_CYCLES=1 build.
module tb_kmap_sweep_checker;
   localparam logic [15:0] TT = 16'hD2B4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   kmap_sweep_checker_if bus0 ();
   kmap_sweep_checker_if bus1 ();

   kmap_sweep_checker #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(2)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   kmap_sweep_checker #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int mode    = 0;
   logic sel_dly2 = 1'b0;
   logic [15:0] tt;
   logic [3:0]  vec0, vec1;
   logic        sop0, pos0;
   logic        dly1 = 1'b0;
   logic        dly2 = 1'b0;

   assign tt   = TT;
   assign vec0 = {bus0.a, bus0.b, bus0.c, bus0.d};
   assign vec1 = {bus1.a, bus1.b, bus1.c, bus1.d};

   // mode 0 golden, 1 sop flipped at 6, 2 both flipped at 3 and 12, 3 both always flipped
   always_comb begin
      sop0 = tt[vec0];
      pos0 = tt[vec0];
      case (mode)
         1: if (vec0 == 4'd6) sop0 = ~sop0;
         2: if (vec0 == 4'd3 || vec0 == 4'd12) begin
               sop0 = ~sop0;
               pos0 = ~pos0;
            end
         3: begin
               sop0 = ~sop0;
               pos0 = ~pos0;
            end
         default: ;
      endcase
   end

   always @(posedge clk) begin
      dly1 <= tt[vec1];
      dly2 <= dly1;
   end

   assign bus0.out_sop = sop0;
   assign bus0.out_pos = pos0;
   assign bus1.out_sop = sel_dly2 ? dly2 : dly1;
   assign bus1.out_pos = sel_dly2 ? dly2 : dly1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task pulse0;
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
   endtask

   task pulse1;
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
   endtask

   initial begin
      bus0.start = 1'b0;
      bus1.start = 1'b0;
      rst_n = 1'b0;
      wait_neg(3);
      check("rst_abcd", 32'(vec0), 0);
      check("rst_busy", 32'(bus0.busy), 0);
      check("rst_done", 32'(bus0.done), 0);
      check("rst_pass", 32'(bus0.pass), 0);
      check("rst_err", 32'(bus0.err_cnt), 0);
      check("rst_first", 32'(bus0.first_err_idx), 0);
      check("rst_dis", 32'(bus0.disagree), 0);
      rst_n = 1'b1;
      wait_neg(2);

      // SETTLE_CYCLES=1 against a two-cycle-delay block: 11 adjacent-bit changes fail
      sel_dly2 = 1'b1;
      pulse1();
      wait_neg(31);
      check("s1_d2_done_early", 32'(bus1.done), 0);
      wait_neg(1);
      check("s1_d2_done", 32'(bus1.done), 1);
      check("s1_d2_err", 32'(bus1.err_cnt), 11);
      check("s1_d2_first", 32'(bus1.first_err_idx), 2);
      check("s1_d2_pass", 32'(bus1.pass), 0);

      // SETTLE_CYCLES=1 against a one-cycle-delay block passes
      sel_dly2 = 1'b0;
      wait_neg(3);
      pulse1();
      wait_neg(32);
      check("s1_d1_done", 32'(bus1.done), 1);
      check("s1_d1_pass", 32'(bus1.pass), 1);
      check("s1_d1_err", 32'(bus1.err_cnt), 0);

      // Golden sweep on the default build
      mode = 0;
      pulse0();
      check("g_busy", 32'(bus0.busy), 1);
      check("g_abcd0", 32'(vec0), 0);
      wait_neg(2);
      check("g_hold0", 32'(vec0), 0);
      wait_neg(1);
      check("g_step1", 32'(vec0), 1);
      wait_neg(44);
      check("g_done_early", 32'(bus0.done), 0);
      check("g_busy_late", 32'(bus0.busy), 1);
      wait_neg(1);
      check("g_done", 32'(bus0.done), 1);
      check("g_pass", 32'(bus0.pass), 1);
      check("g_err", 32'(bus0.err_cnt), 0);
      check("g_dis", 32'(bus0.disagree), 0);
      check("g_busy_end", 32'(bus0.busy), 0);
      check("g_abcd15", 32'(vec0), 15);

      // Single fault, started from DONE
      mode = 1;
      pulse0();
      check("sf_done_drop", 32'(bus0.done), 0);
      check("sf_busy", 32'(bus0.busy), 1);
      wait_neg(48);
      check("sf_done", 32'(bus0.done), 1);
      check("sf_err", 32'(bus0.err_cnt), 1);
      check("sf_first", 32'(bus0.first_err_idx), 6);
      check("sf_dis", 32'(bus0.disagree), 1);
      check("sf_pass", 32'(bus0.pass), 0);

      // Double fault; restart must clear previous results
      mode = 2;
      pulse0();
      check("df_clr_err", 32'(bus0.err_cnt), 0);
      check("df_clr_first", 32'(bus0.first_err_idx), 0);
      check("df_clr_dis", 32'(bus0.disagree), 0);
      check("df_idx0", 32'(vec0), 0);
      wait_neg(48);
      check("df_err", 32'(bus0.err_cnt), 2);
      check("df_first", 32'(bus0.first_err_idx), 3);
      check("df_dis", 32'(bus0.disagree), 0);
      check("df_pass", 32'(bus0.pass), 0);

      // Fully inverted block
      mode = 3;
      pulse0();
      wait_neg(48);
      check("inv_err", 32'(bus0.err_cnt), 16);
      check("inv_first", 32'(bus0.first_err_idx), 0);
      check("inv_pass", 32'(bus0.pass), 0);

      // Starts during a sweep are ignored
      mode = 0;
      pulse0();
      wait_neg(4);
      pulse0();
      check("ign5_abcd", 32'(vec0), 1);
      check("ign5_busy", 32'(bus0.busy), 1);
      wait_neg(14);
      pulse0();
      check("ign20_abcd", 32'(vec0), 6);
      wait_neg(27);
      check("ign_done_early", 32'(bus0.done), 0);
      wait_neg(1);
      check("ign_done", 32'(bus0.done), 1);
      check("ign_pass", 32'(bus0.pass), 1);

      // Asynchronous reset at idx 9
      mode = 1;
      pulse0();
      wait_neg(27);
      check("mr_abcd9", 32'(vec0), 9);
      check("mr_err_pre", 32'(bus0.err_cnt), 1);
      #2 rst_n = 1'b0;
      #1;
      check("mr_abcd", 32'(vec0), 0);
      check("mr_busy", 32'(bus0.busy), 0);
      check("mr_err", 32'(bus0.err_cnt), 0);
      check("mr_first", 32'(bus0.first_err_idx), 0);
      check("mr_dis", 32'(bus0.disagree), 0);
      check("mr_done", 32'(bus0.done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_neg(5);
      check("mr_idle_busy", 32'(bus0.busy), 0);
      check("mr_idle_abcd", 32'(vec0), 0);
      check("mr_idle_done", 32'(bus0.done), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
